fp_sort_engine: RTL
===================

Name: fp_sort_engine

Overview:
- Buffers a burst of up to DEPTH 13-bit floats (1 sign, 4 exponent, 8 mantissa bits) and sorts them into ascending order.
- Sorting uses one shared fp_greater_than comparator that performs one compare-and-swap per cycle, i.e. a sequenced bubble sort.
- Streams the sorted burst back out over a valid/ready interface.
- Sits between a producer of FP13 samples and any consumer needing ordered data, such as a median or percentile stage.

Parameters:
- DEPTH, 8, maximum elements per burst; must be >= 2.
- CNT_W, $clog2(DEPTH+1), width of the element count.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  engine can accept an input word.
- in_data  in  13  FP13 input word.
- in_last  in  1  marks the final word of the burst.
- out_valid  out  1  sorted word valid.
- out_ready  in  1  consumer accepts the sorted word.
- out_data  out  13  sorted FP13 word.
- out_last  out  1  marks the final sorted word.
- busy  out  1  high in SORT and DRAIN states.
- elem_count  out  CNT_W  number of elements captured for the current burst.

Behaviour:
- Reset, one clock and synchronous active-high reset as decided:
  - state = LOAD; write index, read index, pass limit and swapped flag cleared.
  - in_ready=1, out_valid=0, out_last=0, busy=0, elem_count=0, out_data=0.
  - Buffer contents are not reset.
- Reset asserted in any state, including mid-SORT or mid-DRAIN, discards the burst and returns to LOAD on the next edge.
- Ordering rule is exactly the fp_greater_than relation:
  - Positive values beat negative values.
  - Equal signs compare exponent, then mantissa; for negatives the comparison is reversed.
  - -0 orders before +0.
  - No NaN/Inf special cases.
  - Equal words are never swapped, so the sort is stable.
- LOAD state:
  - in_ready=1.
  - Each valid&ready cycle writes in_data to buf[elem_count] and increments elem_count.
  - Accepting a word with in_last=1, or accepting the DEPTH-th word, ends LOAD.
  - When the DEPTH-th word arrives without in_last, the burst is truncated and in_ready is 0 the next cycle.
  - Count 1 goes straight to DRAIN; count >= 2 goes to SORT with idx=0, limit=count-1, swapped=0.
- SORT state:
  - in_ready=0.
  - Each cycle compares buf[idx] against buf[idx+1]. If buf[idx] is greater, the two entries swap at the clock edge and swapped is set.
  - idx increments each cycle.
  - When idx==limit-1, the pass ends:
    - If swapped==0 or limit==1, go to DRAIN.
    - Otherwise limit decrements, idx=0 and swapped=0.
  - Sort time:
    - Already-sorted input takes count-1 cycles.
    - Worst case takes count*(count-1)/2 cycles.
- DRAIN state:
  - out_valid=1 and out_data=buf[rd]; out_last=1 when rd==count-1.
  - rd increments on each out_valid&out_ready.
  - out_data is held stable while out_ready=0.
  - The handshake on the last word returns the engine to LOAD with elem_count=0. The first new word can be accepted on the following cycle.
- Input arriving outside LOAD is back-pressured; no word is ever dropped.

Decomposition:
- Package fp13_pkg:
  - FP13_W=13, EXP_W=4, MANT_W=8, SIGN_BIT=12.
  - typedef fp13_t as logic [12:0].
  - Enum sort_state_t {LOAD, SORT, DRAIN}.
- Sub-module: one instance of the existing fp_greater_than (ports fp1, fp2, gt), fed from buf[idx] and buf[idx+1].
- The buffer is a register array, so that swaps can happen in a single cycle.

Test Plan:
- Mixed-sign burst:
  - Load 13'h0100, 13'h1100, 13'h0080, 13'h0000, with last on the 4th.
  - Output must be 13'h1100, 13'h0000, 13'h0080, 13'h0100, with out_last only on the 4th.
- Pre-sorted early exit:
  - Load 13'h0010, 13'h0020, 13'h0030, with last on the 3rd.
  - busy stays high for exactly 2 SORT cycles before out_valid rises.
- Reverse order, worst case:
  - Load DEPTH=8 descending values 13'h0800 down to 13'h0100.
  - Output is ascending; the sort takes exactly 28 cycles.
- Truncation plus backpressure:
  - Drive 9 words with no in_last.
  - in_ready drops after the 8th word; the 9th is held and accepted at the start of the next burst.
  - Toggle out_ready 1/0 during DRAIN; out_data stays stable while out_ready=0.
- Signed zeros and duplicates:
  - Load 13'h0000, 13'h1000, 13'h0050, 13'h0050.
  - Output must be 13'h1000, 13'h0000, 13'h0050, 13'h0050.
- Reset mid-operation:
  - Assert rst for 1 cycle during SORT, then again during DRAIN.
  - Next cycle: in_ready=1, out_valid=0, elem_count=0; a following 2-element burst sorts correctly.

Source files
------------

// File: rtl/fp13_pkg.sv
// Shared FP13 types for the sort engine: word layout and engine states.
package fp13_pkg;

  localparam int FP13_W   = 13;
  localparam int EXP_W    = 4;
  localparam int MANT_W   = 8;
  localparam int SIGN_BIT = 12;

  typedef logic [FP13_W-1:0] fp13_t;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } sort_state_t;

endpackage

// File: rtl/fp_greater_than.sv
// Combinational FP13 ordering: gt is 1 when fp1 sorts strictly after fp2.
module fp_greater_than
  import fp13_pkg::*;
(
  input  fp13_t fp1,
  input  fp13_t fp2,
  output logic  gt
);

  logic [SIGN_BIT-1:0] mag1;
  logic [SIGN_BIT-1:0] mag2;

  // {exponent, mantissa} compared as one field gives exponent-then-mantissa order.
  always_comb begin
    mag1 = fp1[SIGN_BIT-1:0];
    mag2 = fp2[SIGN_BIT-1:0];
    gt   = 1'b0;
    if (fp1[SIGN_BIT] != fp2[SIGN_BIT]) begin
      gt = !fp1[SIGN_BIT];
    end else if (!fp1[SIGN_BIT]) begin
      gt = (mag1 > mag2);
    end else begin
      gt = (mag1 < mag2);
    end
  end

endmodule

// File: rtl/fp_sort_engine.sv
// Captures a burst of FP13 words, bubble-sorts it in place one compare-and-swap
// per cycle, then streams it out ascending.
module fp_sort_engine
  import fp13_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp13_t            in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output fp13_t            out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] elem_count
);

  localparam int IDX_W = $clog2(DEPTH);

  // Handshakes: a word moves on any rising edge where valid and ready are both
  // high; the sender holds data stable until then, and ready never waits on valid.

  sort_state_t      state;
  sort_state_t      state_d;
  fp13_t            mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W-1:0] limit;
  logic [IDX_W-1:0] rd;
  logic [IDX_W-1:0] last_rd;
  logic             swapped;
  logic             gt;
  logic             accept;
  logic             load_done;
  logic             pass_end;
  logic             sort_done;
  logic             out_fire;

  assign idx_nxt = idx + 1'b1;
  assign last_rd = IDX_W'(count - 1'b1);

  fp_greater_than u_cmp (
    .fp1 (mem[idx]),
    .fp2 (mem[idx_nxt]),
    .gt  (gt)
  );

  // A swap on the final compare of a pass still forces another pass.
  always_comb begin
    accept    = (state == LOAD) && in_valid;
    load_done = accept && (in_last || (count == CNT_W'(DEPTH - 1)));
    pass_end  = (state == SORT) && (idx == limit - 1'b1);
    sort_done = pass_end && (!(swapped || gt) || (limit == IDX_W'(1)));
    out_fire  = (state == DRAIN) && out_ready;
    state_d   = state;
    case (state)
      LOAD:    if (load_done) state_d = (count == '0) ? DRAIN : SORT;
      SORT:    if (sort_done) state_d = DRAIN;
      DRAIN:   if (out_fire && (rd == last_rd)) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      idx     <= '0;
      limit   <= '0;
      swapped <= 1'b0;
      rd      <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) count <= count + 1'b1;
          if (load_done) begin
            idx     <= '0;
            limit   <= IDX_W'(count);
            swapped <= 1'b0;
            rd      <= '0;
          end
        end
        SORT: begin
          if (pass_end) begin
            idx     <= '0;
            limit   <= limit - 1'b1;
            swapped <= 1'b0;
          end else begin
            idx     <= idx_nxt;
            swapped <= swapped || gt;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            rd <= rd + 1'b1;
            if (rd == last_rd) begin
              count <= '0;
              rd    <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Contents are deliberately unreset; count decides which entries are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[count[IDX_W-1:0]] <= in_data;
    end else if ((state == SORT) && gt) begin
      mem[idx]     <= mem[idx_nxt];
      mem[idx_nxt] <= mem[idx];
    end
  end

  assign in_ready   = (state == LOAD);
  assign out_valid  = (state == DRAIN);
  assign out_data   = out_valid ? mem[rd] : '0;
  assign out_last   = out_valid && (rd == last_rd);
  assign busy       = (state != LOAD);
  assign elem_count = count;

endmodule
